// File: rtl/sdram_wb_arbiter.sv
// Round-robin bridge from NCH Wishbone-classic masters to the SDRAM controller req/ack port,
// with programmable wb_ack delay and controller-reset stretch.
module sdram_wb_arbiter #(
  parameter  int NCH     = 2,
  parameter  int AW      = 21,
  parameter  int DW      = 16,
  parameter  int ACK_DLY = 2,
  parameter  int RST_DLY = 3,
  localparam int BW      = DW / 8
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              sys_reset,
  input  logic              sdram_ready,
  input  logic [NCH-1:0]    wb_stb,
  input  logic [NCH-1:0]    wb_we,
  input  logic [NCH*BW-1:0] wb_sel,
  input  logic [NCH*AW-1:0] wb_adr,
  input  logic [NCH*DW-1:0] wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic [NCH-1:0]    wb_ack,
  output logic              ctl_rst_n,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic [AW-1:0]     sdram_addr,
  output logic [DW-1:0]     sdram_wdata,
  input  logic [DW-1:0]     sdram_rdata,
  output logic [BW-1:0]     sdram_dqm,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DLY, S_HOLD} state_t;

  state_t          r_state, w_state_n;
  logic [1:0]      r_sync;
  logic [3:0]      r_rst_cnt;
  logic            r_ctl_rst_n;
  logic [1:0]      r_grant, r_ptr, w_pick, w_ptr_nxt;
  logic [AW-1:0]   r_addr, w_p_adr;
  logic [DW-1:0]   r_wdata, r_dat_o, w_p_dat;
  logic [BW-1:0]   r_dqm, w_p_sel;
  logic            r_we, r_abort, w_p_we, w_g_stb, w_found;
  logic            w_sys_rst, w_grant_ok, w_ack_hit, w_abort;
  logic [2:0]      r_dly_cnt;

  assign w_sys_rst = r_sync[1];

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '1;
      r_rst_cnt   <= '0;
      r_ctl_rst_n <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], sys_reset};
      if (w_sys_rst) begin
        r_rst_cnt   <= '0;
        r_ctl_rst_n <= 1'b0;
      end else if (!r_ctl_rst_n) begin
        if (r_rst_cnt == 4'(RST_DLY - 1)) r_ctl_rst_n <= 1'b1;
        else                              r_rst_cnt   <= r_rst_cnt + 4'd1;
      end
    end
  end

  // Two passes: channels at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!w_found && wb_stb[i] && (i >= 32'(r_ptr))) begin
        w_found = 1'b1;
        w_pick  = 2'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!w_found && wb_stb[i]) begin
        w_found = 1'b1;
        w_pick  = 2'(i);
      end
    end
  end

  always_comb begin
    w_g_stb = 1'b0;
    w_p_we  = 1'b0;
    w_p_adr = '0;
    w_p_dat = '0;
    w_p_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r_grant == 2'(i)) w_g_stb = wb_stb[i];
      if (w_pick == 2'(i)) begin
        w_p_we  = wb_we[i];
        w_p_adr = wb_adr[i*AW +: AW];
        w_p_dat = wb_dat_i[i*DW +: DW];
        w_p_sel = wb_sel[i*BW +: BW];
      end
    end
  end

  assign w_grant_ok = (r_state == S_IDLE) && sdram_ready && !w_sys_rst && w_found;
  assign w_ack_hit  = r_we ? sdram_wr_ack : sdram_rd_ack;
  assign w_abort    = r_abort || !w_g_stb;
  assign w_ptr_nxt  = (r_grant == 2'(NCH - 1)) ? 2'd0 : r_grant + 2'd1;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: if (w_grant_ok) w_state_n = S_REQ;
      S_REQ:  if (w_ack_hit) begin
                if (ACK_DLY == 1) w_state_n = w_abort ? S_IDLE : S_HOLD;
                else              w_state_n = S_DLY;
              end
      S_DLY:  if (r_dly_cnt == 3'(ACK_DLY - 2)) w_state_n = w_abort ? S_IDLE : S_HOLD;
      S_HOLD: if (!w_g_stb) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (w_sys_rst) w_state_n = S_IDLE;

    sdram_wr_req = (r_state == S_REQ) && r_we;
    sdram_rd_req = (r_state == S_REQ) && !r_we;
    wb_ack       = '0;
    for (int unsigned i = 0; i < NCH; i++)
      wb_ack[i] = (r_state == S_HOLD) && (r_grant == 2'(i)) && wb_stb[i];
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_grant   <= '0;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dqm     <= '0;
      r_we      <= 1'b0;
      r_abort   <= 1'b0;
      r_dat_o   <= '0;
      r_dly_cnt <= '0;
    end else begin
      if (w_grant_ok) begin
        r_grant <= w_pick;
        r_addr  <= w_p_adr;
        r_wdata <= w_p_dat;
        r_dqm   <= w_p_we ? ~w_p_sel : '0;
        r_we    <= w_p_we;
        r_abort <= 1'b0;
      end else if ((r_state == S_REQ || r_state == S_DLY) && !w_g_stb) begin
        r_abort <= 1'b1;
      end
      if (r_state == S_REQ && w_ack_hit) begin
        r_dly_cnt <= '0;
        if (!r_we) r_dat_o <= sdram_rdata;
      end else if (r_state == S_DLY) begin
        r_dly_cnt <= r_dly_cnt + 3'd1;
      end
      // Aborted transactions also pass the turn on; a sys_reset flush does not.
      if (r_state != S_IDLE && w_state_n == S_IDLE && !w_sys_rst) r_ptr <= w_ptr_nxt;
    end
  end

  assign ctl_rst_n   = r_ctl_rst_n;
  assign sdram_addr  = r_addr;
  assign sdram_wdata = r_wdata;
  assign sdram_dqm   = r_dqm;
  assign wb_dat_o    = r_dat_o;
  assign grant       = r_grant;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed self-checking bench for sdram_wb_arbiter (NCH=2, AW=21, DW=16, ACK_DLY=2, RST_DLY=3).
module tb_sdram_wb_arbiter;
  localparam int NCH     = 2;
  localparam int AW      = 21;
  localparam int DW      = 16;
  localparam int BW      = DW / 8;
  localparam int ACK_DLY = 2;
  localparam int RST_DLY = 3;

  logic              clk_p = 1'b0;
  logic              rst_n;
  logic              sys_reset;
  logic              sdram_ready;
  logic [NCH-1:0]    wb_stb;
  logic [NCH-1:0]    wb_we;
  logic [NCH*BW-1:0] wb_sel;
  logic [NCH*AW-1:0] wb_adr;
  logic [NCH*DW-1:0] wb_dat_i;
  logic [DW-1:0]     wb_dat_o;
  logic [NCH-1:0]    wb_ack;
  logic              ctl_rst_n;
  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic [AW-1:0]     sdram_addr;
  logic [DW-1:0]     sdram_wdata;
  logic [DW-1:0]     sdram_rdata;
  logic [BW-1:0]     sdram_dqm;
  logic [1:0]        grant;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sdram_wb_arbiter #(
    .NCH(NCH), .AW(AW), .DW(DW), .ACK_DLY(ACK_DLY), .RST_DLY(RST_DLY)
  ) u_dut (
    .clk_p(clk_p), .rst_n(rst_n), .sys_reset(sys_reset), .sdram_ready(sdram_ready),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .ctl_rst_n(ctl_rst_n),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata), .sdram_rdata(sdram_rdata),
    .sdram_dqm(sdram_dqm), .grant(grant)
  );

  always #5 clk_p = ~clk_p;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (!(sdram_wr_req || sdram_rd_req) && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(sdram_wr_req || sdram_rd_req), 32'd1);
  endtask

  // One write round under contention; the master drops stb for a cycle after its ack.
  task automatic rr_xact(input logic [1:0] exp_g);
    int unsigned n = 0;
    wait_req("rr_req");
    check("rr_grant", 32'(grant), 32'(exp_g));
    sdram_wr_ack = 1'b1;
    tick();
    sdram_wr_ack = 1'b0;
    while (wb_ack == '0 && n < 20) begin
      tick();
      n++;
    end
    check("rr_ack", 32'(wb_ack), 32'(2'b01 << exp_g));
    wb_stb[exp_g[0]] = 1'b0;
    tick();
    wb_stb = 2'b11;
  endtask

  initial begin
    rst_n = 1'b0; sys_reset = 1'b1; sdram_ready = 1'b0;
    wb_stb = '0; wb_we = '0; wb_sel = '0; wb_adr = '0; wb_dat_i = '0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_rdata = '0;

    // 1: reset state and controller reset stretch
    repeat (3) tick();
    check("rst_ack",   32'(wb_ack),       32'd0);
    check("rst_wrreq", 32'(sdram_wr_req), 32'd0);
    check("rst_rdreq", 32'(sdram_rd_req), 32'd0);
    check("rst_ctl",   32'(ctl_rst_n),    32'd0);
    check("rst_grant", 32'(grant),        32'd0);
    check("rst_dato",  32'(wb_dat_o),     32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    sys_reset = 1'b0;
    repeat (2 + RST_DLY - 1) tick();
    check("ctl_early", 32'(ctl_rst_n), 32'd0);
    tick();
    check("ctl_release", 32'(ctl_rst_n), 32'd1);

    // 2: ch0 write, wrong-type ack ignored, delayed wb_ack
    sdram_ready = 1'b1;
    wb_we = 2'b01; wb_sel[1:0] = 2'b01;
    wb_adr[0 +: AW] = 21'h1234; wb_dat_i[0 +: DW] = 16'hBEEF;
    wb_stb = 2'b01;
    check("wr_idle", 32'(sdram_wr_req), 32'd0);
    tick();
    check("wr_req",   32'(sdram_wr_req), 32'd1);
    check("wr_rdreq", 32'(sdram_rd_req), 32'd0);
    check("wr_addr",  32'(sdram_addr),   32'h1234);
    check("wr_wdata", 32'(sdram_wdata),  32'hBEEF);
    check("wr_dqm",   32'(sdram_dqm),    32'h2);
    check("wr_grant", 32'(grant),        32'd0);
    sdram_rd_ack = 1'b1;
    tick();
    sdram_rd_ack = 1'b0;
    check("wr_wrongack", 32'(sdram_wr_req), 32'd1);
    check("wr_noack",    32'(wb_ack),       32'd0);
    sdram_wr_ack = 1'b1;
    tick();
    sdram_wr_ack = 1'b0;
    check("wr_reqdrop", 32'(sdram_wr_req), 32'd0);
    check("wr_dlyack",  32'(wb_ack),       32'd0);
    tick();
    check("wr_ack",     32'(wb_ack), 32'h1);
    tick();
    check("wr_ackhold", 32'(wb_ack), 32'h1);
    wb_stb = 2'b00;
    #1;
    check("wr_ackdrop", 32'(wb_ack), 32'd0);
    tick();

    // 3: ch1 read with data capture
    wb_we = 2'b00; wb_sel[3:2] = 2'b11; wb_adr[AW +: AW] = 21'h0ABC;
    wb_stb = 2'b10;
    tick();
    check("rd_req",   32'(sdram_rd_req), 32'd1);
    check("rd_wrreq", 32'(sdram_wr_req), 32'd0);
    check("rd_grant", 32'(grant),        32'd1);
    check("rd_dqm",   32'(sdram_dqm),    32'd0);
    check("rd_addr",  32'(sdram_addr),   32'h0ABC);
    sdram_wr_ack = 1'b1;
    tick();
    sdram_wr_ack = 1'b0;
    check("rd_wrongack", 32'(sdram_rd_req), 32'd1);
    sdram_rd_ack = 1'b1; sdram_rdata = 16'h5A5A;
    tick();
    sdram_rd_ack = 1'b0; sdram_rdata = '0;
    check("rd_reqdrop", 32'(sdram_rd_req), 32'd0);
    check("rd_data",    32'(wb_dat_o),     32'h5A5A);
    check("rd_dlyack",  32'(wb_ack),       32'd0);
    tick();
    check("rd_ack",     32'(wb_ack), 32'h2);
    tick();
    check("rd_ackhold", 32'(wb_ack), 32'h2);
    wb_stb = 2'b00;
    #1;
    check("rd_ackdrop", 32'(wb_ack), 32'd0);
    tick();
    check("rd_datahold", 32'(wb_dat_o), 32'h5A5A);

    // 4: both channels contending -> strict alternation
    wb_we = 2'b11; wb_stb = 2'b11;
    for (int t = 0; t < 6; t++) rr_xact(2'(t % 2));
    wb_stb = 2'b00;
    tick();

    // 5: ch0 aborts during REQ
    wb_we = 2'b01; wb_stb = 2'b01;
    tick();
    check("ab_req",   32'(sdram_wr_req), 32'd1);
    check("ab_grant", 32'(grant),        32'd0);
    wb_stb = 2'b00;
    tick();
    check("ab_reqheld1", 32'(sdram_wr_req), 32'd1);
    tick();
    check("ab_reqheld2", 32'(sdram_wr_req), 32'd1);
    sdram_wr_ack = 1'b1;
    tick();
    sdram_wr_ack = 1'b0;
    check("ab_reqdrop", 32'(sdram_wr_req), 32'd0);
    check("ab_noack1",  32'(wb_ack),       32'd0);
    tick();
    check("ab_noack2", 32'(wb_ack), 32'd0);
    wb_we = 2'b00; wb_stb = 2'b10;
    tick();
    check("ab_idle_rdreq", 32'(sdram_rd_req), 32'd1);
    check("ab_idle_grant", 32'(grant),        32'd1);

    // 6: sys_reset during REQ, then no grant while sdram_ready=0
    sys_reset = 1'b1;
    repeat (3) tick();
    check("sr_rdreq", 32'(sdram_rd_req), 32'd0);
    check("sr_ctl",   32'(ctl_rst_n),    32'd0);
    check("sr_ack",   32'(wb_ack),       32'd0);
    sys_reset = 1'b0; sdram_ready = 1'b0;
    wb_we = 2'b01; wb_stb = 2'b01;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("nr_noreq", 32'(sdram_wr_req || sdram_rd_req), 32'd0);
    end
    check("sr_ctl_release", 32'(ctl_rst_n), 32'd1);
    sdram_ready = 1'b1;
    tick();
    check("rdy_wrreq", 32'(sdram_wr_req), 32'd1);
    check("rdy_grant", 32'(grant),        32'd0);
    check("end_dato",  32'(wb_dat_o),     32'h5A5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
